// File: rtl/alu_exec_unit.sv
`default_nettype none
// alu_exec_unit -- RV32I execute unit: single-cycle add/sub/logic/compare, bit-serial shifts with start/ready/done.
// Revision 1.0
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             in_ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;

  localparam logic [1:0] KIND_SLL = 2'b01;
  localparam logic [1:0] KIND_SRL = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    cnt;
  logic [1:0]       kind;

  logic [SW-1:0]    shamt;
  logic             is_shift_op;
  logic             accept;
  logic             go_serial;
  logic             last_step;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic [WIDTH-1:0] acc_step;

  assign shamt       = b[SW-1:0];
  assign is_shift_op = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign in_ready    = (state == IDLE);
  assign accept      = start && in_ready;
  assign go_serial   = accept && is_shift_op && (shamt != '0);
  assign last_step   = (state == SHIFT) && (cnt == SW'(1));

  // Shift ops only reach this path with shamt == 0, where the result is just a.
  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (op)
      OP_ADD:   single_res = a + b;
      OP_SUB:   single_res = a - b;
      OP_AND:   single_res = a & b;
      OP_OR:    single_res = a | b;
      OP_XOR:   single_res = a ^ b;
      OP_SLL,
      OP_SRL,
      OP_SRA:   single_res = a;
      OP_SLT:   single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  single_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASSB: single_res = b;
      default: begin
        single_res = '0;
        single_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    acc_step = acc;
    case (kind)
      KIND_SLL: acc_step = {acc[WIDTH-2:0], 1'b0};
      KIND_SRL: acc_step = {1'b0, acc[WIDTH-1:1]};
      default:  acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_serial) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      kind    <= 2'b00;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == SHIFT) begin
        acc <= acc_step;
        cnt <= cnt - SW'(1);
        if (last_step) begin
          result  <= acc_step;
          zero    <= (acc_step == '0);
          illegal <= 1'b0;
          done    <= 1'b1;
        end
      end else if (go_serial) begin
        acc  <= a;
        cnt  <= shamt;
        kind <= op[1:0];
      end else if (accept) begin
        result  <= single_res;
        zero    <= (single_res == '0);
        illegal <= single_ill;
        done    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
